int_mem_loader: RTL and testbench



---
 rtl/int_mem_loader_if.sv | 25 ++
 rtl/int_mem_loader.sv | 98 +++++++++
 tb/tb_int_mem_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/int_mem_loader_if.sv
// rtl/int_mem_loader_if.sv - address/data stream and memory write bus of the loader
interface int_mem_loader_if #(
   parameter int IO_DATA_WIDTH = 16
);
   logic [IO_DATA_WIDTH-1:0] a_input;
   logic                     a_valid;
   logic                     a_ready;
   logic [IO_DATA_WIDTH-1:0] b_input;
   logic                     b_valid;
   logic                     b_ready;
   logic [14:0]              mem_addr;
   logic [IO_DATA_WIDTH-1:0] mem_din;
   logic                     input_mem_we;
   logic                     kernel_mem_we;

   modport master (
      output a_input, a_valid, b_input, b_valid,
      input  a_ready, b_ready, mem_addr, mem_din, input_mem_we, kernel_mem_we
   );

   modport slave (
      input  a_input, a_valid, b_input, b_valid,
      output a_ready, b_ready, mem_addr, mem_din, input_mem_we, kernel_mem_we
   );
endinterface

// File: rtl/int_mem_loader.sv
// rtl/int_mem_loader.sv - loads input/kernel memories from an address/data pair stream
module int_mem_loader #(
   parameter int IO_DATA_WIDTH = 16,
   parameter int INPUT_WORDS   = 1 << 15,
   parameter int KERNEL_WORDS  = 1 << 9
) (
   input  logic            clk,
   input  logic            arst_n_in,
   int_mem_loader_if.slave bus,
   input  logic            start_load,
   input  logic            fsm_done,
   output logic            data_ready,
   output logic            load_error,
   output logic            busy
);
   localparam int ICW = $clog2(INPUT_WORDS + 1);
   localparam int KCW = $clog2(KERNEL_WORDS + 1);
   localparam logic [15:0]    IN_LIM  = 16'(INPUT_WORDS);
   localparam logic [15:0]    K_LIM   = 16'(KERNEL_WORDS);
   localparam logic [ICW-1:0] IN_FULL = ICW'(INPUT_WORDS);
   localparam logic [KCW-1:0] K_FULL  = KCW'(KERNEL_WORDS);

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

   state_t         state, state_nx;
   logic [ICW-1:0] in_cnt, in_cnt_nx;
   logic [KCW-1:0] k_cnt, k_cnt_nx;
   logic           accept, sel_k, is_k, is_i;
   logic [15:0]    offset;

   assign bus.a_ready = (state == LOAD);
   assign bus.b_ready = (state == LOAD);
   assign busy        = (state == LOAD) || (state == FLUSH);
   assign data_ready  = (state == DONE);

   // A pair arriving alongside start_load belongs to the abandoned load.
   assign accept = (state == LOAD) && bus.a_valid && bus.b_valid && !start_load;
   assign sel_k  = bus.a_input[IO_DATA_WIDTH-1];
   assign offset = {1'b0, bus.a_input[14:0]};
   assign is_k   = accept && sel_k && (offset < K_LIM);
   assign is_i   = accept && !sel_k && (offset < IN_LIM);

   assign in_cnt_nx = (is_i && (in_cnt != IN_FULL)) ? in_cnt + ICW'(1) : in_cnt;
   assign k_cnt_nx  = (is_k && (k_cnt != K_FULL)) ? k_cnt + KCW'(1) : k_cnt;

   always_ff @(posedge clk) begin
      if (!arst_n_in) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (start_load) begin
         state_nx = LOAD;
      end else begin
         case (state)
            IDLE:  state_nx = IDLE;
            LOAD:  if ((is_i || is_k) && (in_cnt_nx == IN_FULL) && (k_cnt_nx == K_FULL))
                      state_nx = FLUSH;
            FLUSH: state_nx = DONE;
            DONE:  if (fsm_done) state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n_in) begin
         in_cnt            <= '0;
         k_cnt             <= '0;
         load_error        <= 1'b0;
         bus.input_mem_we  <= 1'b0;
         bus.kernel_mem_we <= 1'b0;
         bus.mem_addr      <= '0;
         bus.mem_din       <= '0;
      end else begin
         bus.input_mem_we  <= is_i;
         bus.kernel_mem_we <= is_k;
         if (is_i || is_k) begin
            bus.mem_addr <= sel_k ? {6'd0, bus.a_input[8:0]} : bus.a_input[14:0];
            bus.mem_din  <= bus.b_input;
         end
         if (start_load) begin
            in_cnt     <= '0;
            k_cnt      <= '0;
            load_error <= 1'b0;
         end else begin
            in_cnt <= in_cnt_nx;
            k_cnt  <= k_cnt_nx;
            if (accept && !is_i && !is_k)
               load_error <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_int_mem_loader.sv
// tb/tb_int_mem_loader.sv - self-checking bench for int_mem_loader (INPUT_WORDS=4, KERNEL_WORDS=2)
module tb_int_mem_loader;
   localparam int KI = 2;
   localparam int KK = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic arst_n_in, start_load, fsm_done;
   logic data_ready, load_error, busy;

   int_mem_loader_if #(.IO_DATA_WIDTH(16)) bus ();

   int_mem_loader #(
      .IO_DATA_WIDTH(16),
      .INPUT_WORDS  (4),
      .KERNEL_WORDS (2)
   ) dut (
      .clk       (clk),
      .arst_n_in (arst_n_in),
      .bus       (bus),
      .start_load(start_load),
      .fsm_done  (fsm_done),
      .data_ready(data_ready),
      .load_error(load_error),
      .busy      (busy)
   );

   typedef struct {
      int          kind;
      logic [14:0] addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
      int          kind;
   } vec_t;

   wr_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   wr_t got;
   always @(negedge clk) begin
      if (bus.input_mem_we === 1'b1 || bus.kernel_mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'({bus.input_mem_we, bus.kernel_mem_we}), 32'd0);
         end else begin
            got = exp_q.pop_front();
            check("strobe_kind", 32'({bus.input_mem_we, bus.kernel_mem_we}), 32'(got.kind));
            check("mem_addr", 32'(bus.mem_addr), 32'(got.addr));
            check("mem_din", 32'(bus.mem_din), 32'(got.data));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] a, input logic [15:0] d, input int kind);
      wr_t w;
      bus.a_input = a;
      bus.b_input = d;
      bus.a_valid = 1'b1;
      bus.b_valid = 1'b1;
      if (kind != 0) begin
         w.kind = kind;
         w.addr = (kind == KK) ? {6'd0, a[8:0]} : a[14:0];
         w.data = d;
         exp_q.push_back(w);
      end
      tick();
   endtask

   task automatic idle_bus();
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start_load = 1'b1;
      tick();
      start_load = 1'b0;
   endtask

   vec_t vecs[6];

   initial begin
      vecs[0] = '{16'h0000, 16'd11, KI};
      vecs[1] = '{16'h0001, 16'd22, KI};
      vecs[2] = '{16'h8000, 16'd33, KK};
      vecs[3] = '{16'h0002, 16'd44, KI};
      vecs[4] = '{16'h8001, 16'd55, KK};
      vecs[5] = '{16'h0003, 16'd66, KI};

      arst_n_in   = 1'b0;
      start_load  = 1'b0;
      fsm_done    = 1'b0;
      bus.a_input = '0;
      bus.b_input = '0;
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      repeat (3) tick();
      arst_n_in = 1'b1;
      tick();

      check("rst_data_ready", 32'(data_ready), 0);
      check("rst_load_error", 32'(load_error), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_ready", 32'({bus.a_ready, bus.b_ready}), 0);
      check("rst_we", 32'({bus.input_mem_we, bus.kernel_mem_we}), 0);
      check("rst_addr_din", 32'({bus.mem_addr, bus.mem_din}), 0);

      bus.a_valid = 1'b1;
      bus.b_valid = 1'b1;
      bus.b_input = 16'h0005;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_a_ready", 32'(bus.a_ready), 0);
      end
      idle_bus();

      pulse_start();
      check("load_ready", 32'({bus.a_ready, bus.b_ready}), 32'h3);
      for (int i = 0; i < 6; i++) send(vecs[i].a, vecs[i].d, vecs[i].kind);
      idle_bus();
      check("flush_busy", 32'(busy), 1);
      check("flush_not_ready", 32'(data_ready), 0);
      check("flush_a_ready", 32'(bus.a_ready), 0);
      tick();
      check("done_data_ready", 32'(data_ready), 1);
      check("done_busy", 32'(busy), 0);
      check("done_error", 32'(load_error), 0);
      check("done_drained", 32'(exp_q.size()), 0);

      fsm_done = 1'b1;
      tick();
      fsm_done = 1'b0;
      check("fsm_done_release", 32'(data_ready), 0);
      check("fsm_done_idle", 32'({busy, bus.a_ready}), 0);

      pulse_start();
      bus.a_valid = 1'b1;
      bus.b_valid = 1'b0;
      bus.a_input = 16'h0001;
      bus.b_input = 16'h0099;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("lone_a_ready", 32'(bus.a_ready), 1);
      end
      send(16'h0002, 16'h00AB, KI);
      check("err_before", 32'(load_error), 0);
      send(16'h8002, 16'd7, 0);
      check("err_rise", 32'(load_error), 1);
      send(16'h0004, 16'd8, 0);
      idle_bus();
      tick();
      check("err_sticky", 32'(load_error), 1);
      check("err_in_cnt", 32'(dut.in_cnt), 1);
      check("err_k_cnt", 32'(dut.k_cnt), 0);

      send(16'h0000, 16'd1, KI);
      send(16'h0001, 16'd2, KI);
      send(16'h0003, 16'd3, KI);
      send(16'h8000, 16'd4, KK);
      check("one_kernel_missing", 32'(busy), 1);
      send(16'h8001, 16'd5, KK);
      idle_bus();
      tick();
      check("done2_data_ready", 32'(data_ready), 1);
      check("done2_error_kept", 32'(load_error), 1);

      start_load = 1'b1;
      fsm_done   = 1'b1;
      tick();
      start_load = 1'b0;
      fsm_done   = 1'b0;
      check("both_busy", 32'(busy), 1);
      check("both_data_ready", 32'(data_ready), 0);
      check("both_in_cnt", 32'(dut.in_cnt), 0);
      check("both_k_cnt", 32'(dut.k_cnt), 0);
      check("both_error_clr", 32'(load_error), 0);

      for (int i = 0; i < 5; i++) send(16'(i % 4), 16'(16'h100 + i), KI);
      idle_bus();
      tick();
      check("sat_in_cnt", 32'(dut.in_cnt), 4);
      check("sat_still_load", 32'({busy, data_ready}), 32'h2);
      send(16'h8000, 16'h0042, KK);
      idle_bus();
      tick();
      check("sat_k_cnt", 32'(dut.k_cnt), 1);

      send(16'h0001, 16'h0077, KI);
      arst_n_in   = 1'b0;
      bus.a_input = 16'h8001;
      bus.b_input = 16'h0088;
      tick();
      check("rst_cancel_we", 32'({bus.input_mem_we, bus.kernel_mem_we}), 0);
      check("rst_cancel_busy", 32'(busy), 0);
      arst_n_in = 1'b1;
      idle_bus();
      tick();
      check("rst_idle", 32'({busy, data_ready, bus.a_ready}), 0);
      check("rst_counts", 32'({dut.in_cnt, dut.k_cnt}), 0);

      repeat (2) tick();
      check("final_drained", 32'(exp_q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
